uib_arbiter: RTL and testbench
==============================

// Module: uib_arbiter
// PURPOSE
//  Parametrised successor of the single-master uib bus. N_MASTERS bus masters share N_SLAVES slaves.
//  Behaviour beyond uib: round-robin arbitration, a bus watchdog timeout, and an error response for
//  decode misses or hung slaves. Sits in the unisys top between the cpu/DMA masters and the
//  mainmem/uart/timer slaves. It carries one transaction at a time.
// PARAMETERS
//  XLEN         32            data width; address width is XLEN-SLAVE_WIDTH
//  SLAVE_WIDTH  4             width of the slave-number field master_num
//  N_MASTERS    2             number of masters (>=1)
//  N_SLAVES     3             number of slaves (1..2**SLAVE_WIDTH)
//  TIMEOUT      256           max cycles a granted transfer waits for slave_ready (>=2)
//  ERR_DATA     32'hDEADBEEF  read data returned with an error response
// PORTS  (all vectors flattened, index i occupies [i*W +: W])
//  clk           in   1                         clock, all state on posedge
//  rst           in   1                         async active-high reset
//  master_dat_o  in   N_MASTERS*XLEN            write data from master
//  master_addr   in   N_MASTERS*(XLEN-SW)       word/byte address within slave
//  master_num    in   N_MASTERS*SW              target slave number
//  master_mode   in   N_MASTERS*3               access size/sign mode, passed through
//  master_wen    in   N_MASTERS                 1=write 0=read
//  master_req    in   N_MASTERS                 request, held until master_ready
//  master_dat_i  out  N_MASTERS*XLEN            read data to master
//  master_ready  out  N_MASTERS                 1-cycle completion pulse
//  master_err    out  N_MASTERS                 qualifies master_ready: transfer failed
//  slave_dat_i   out  N_SLAVES*XLEN             write data to slave
//  slave_addr    out  N_SLAVES*(XLEN-SW)        address to slave
//  slave_mode    out  N_SLAVES*3                mode to slave
//  slave_wen     out  N_SLAVES                  write enable to slave
//  slave_req     out  N_SLAVES                  request to slave
//  slave_dat_o   in   N_SLAVES*XLEN             read data from slave
//  slave_ready   in   N_SLAVES                  slave completion pulse
// BEHAVIOUR
//  Reset (async, rst=1)
//   - state=IDLE; grant=0; watchdog=0; rr_last=N_MASTERS-1, so master 0 wins first.
//   - All req/ready/err/wen outputs are 0; data, addr and mode outputs are 0.
//   - Reset mid-transfer drops slave_req immediately and gives no ready to the master.
//  Handshake
//   - A master holds req with stable addr/num/mode/wen/dat until it sees master_ready=1 (exactly 1 cycle).
//   - A slave pulses slave_ready for 1 cycle; slave_dat_o is valid in that cycle.
//  FSM: IDLE -> BUSY | ERR ; BUSY -> IDLE | ERR | IDLE(abort) ; ERR -> IDLE
//   IDLE
//    - On a clock edge with any master_req=1: grant = first requester after rr_last, cyclic.
//    - rr_last <= grant. Grant is registered.
//    - If num(grant) < N_SLAVES -> BUSY; else -> ERR (decode miss).
//   BUSY
//    - Combinationally drive the slave selected by num(grant) with the granted master's live
//      req/addr/mode/wen/dat. All other slaves see 0.
//    - slave_ready(sel) routes combinationally: master_ready(grant)=1 and
//      master_dat_i(grant)=slave_dat_o(sel) in the same cycle. Next state IDLE.
//    - The watchdog increments each BUSY cycle. At watchdog==TIMEOUT-1 with no ready -> ERR,
//      and slave_req drops.
//    - If ready and timeout fall in the same cycle, ready wins.
//    - Granted master drops req before ready (protocol violation) -> IDLE, no response.
//    - watchdog clears on leaving BUSY.
//   ERR
//    - One cycle: master_ready(grant)=1, master_err(grant)=1, master_dat_i(grant)=ERR_DATA.
//    - No slave is driven. Next state IDLE.
//  Timing and fairness
//   - Latency: req seen at edge 0 -> slave_req visible after edge 0 (cycle 1).
//   - A zero-wait slave completes in cycle 1. Minimum gap between grants is 1 IDLE cycle.
//   - Non-granted masters see ready=0 and err=0; their master_dat_i is 0.
//   - Round robin guarantees every requester is served within N_MASTERS grants.
//   - N_MASTERS=1 degenerates to uib plus the timeout.
//   - master_err is never 1 without master_ready.
// TESTING
//  1. Reset, then M0 reads slave 0 at addr 0x10; slave returns 0x12345678 one cycle later
//     -> slave_req(0) rises cycle 1; M0 ready=1, err=0, dat=0x12345678.
//  2. M0 and M1 request continuously -> grants alternate M0,M1,M0,M1; each transfer is
//     separated by 1 IDLE cycle.
//  3. M1 writes 0xA5A5A5A5 to num=7 (>=N_SLAVES) -> no slave_req ever asserted; cycle 1 gives
//     M1 ready=1, err=1, dat=0xDEADBEEF.
//  4. M0 targets slave 2, which never responds -> slave_req(2) high for exactly TIMEOUT cycles,
//     then M0 ready=1, err=1 in the next cycle.
//  5. slave_ready arrives in the TIMEOUT-th BUSY cycle -> normal response with err=0.
//     Separately, rst pulsed mid-BUSY -> all outputs 0 at once; first post-reset grant goes to M0.
//  6. N_MASTERS=4 with M1 and M3 requesting after an M3 grant -> M1 is granted next.

Source files
------------

// File: rtl/uib_arbiter.sv
// Round-robin arbiter sharing N_SLAVES uib slaves among N_MASTERS masters, one transfer at a time,
// with a bus watchdog and an error response for decode misses and hung slaves.
module uib_arbiter #(
    parameter int              XLEN        = 32,
    parameter int              SLAVE_WIDTH = 4,
    parameter int              N_MASTERS   = 2,
    parameter int              N_SLAVES    = 3,
    parameter int              TIMEOUT     = 256,
    parameter logic [XLEN-1:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_MASTERS*XLEN-1:0]              master_dat_o,
    input  logic [N_MASTERS*(XLEN-SLAVE_WIDTH)-1:0] master_addr,
    input  logic [N_MASTERS*SLAVE_WIDTH-1:0]       master_num,
    input  logic [N_MASTERS*3-1:0]                 master_mode,
    input  logic [N_MASTERS-1:0]                   master_wen,
    input  logic [N_MASTERS-1:0]                   master_req,
    output logic [N_MASTERS*XLEN-1:0]              master_dat_i,
    output logic [N_MASTERS-1:0]                   master_ready,
    output logic [N_MASTERS-1:0]                   master_err,
    output logic [N_SLAVES*XLEN-1:0]               slave_dat_i,
    output logic [N_SLAVES*(XLEN-SLAVE_WIDTH)-1:0] slave_addr,
    output logic [N_SLAVES*3-1:0]                  slave_mode,
    output logic [N_SLAVES-1:0]                    slave_wen,
    output logic [N_SLAVES-1:0]                    slave_req,
    input  logic [N_SLAVES*XLEN-1:0]               slave_dat_o,
    input  logic [N_SLAVES-1:0]                    slave_ready
);
    localparam int AW  = XLEN - SLAVE_WIDTH;
    localparam int GW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  RR_INIT = GW'(N_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t           state, state_nxt;
    logic [GW-1:0]    grant, grant_nxt, rr_last, rr_last_nxt, pick;
    logic [WDW-1:0]   wdog, wdog_nxt;
    logic             found;
    logic [SLAVE_WIDTH-1:0] pick_num, g_num;
    logic             g_req, s_rdy;
    logic [XLEN-1:0]  s_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            rr_last <= RR_INIT;
            wdog    <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_last <= rr_last_nxt;
            wdog    <= wdog_nxt;
        end
    end

    // Cyclic search starting just after the last winner.
    always_comb begin
        int idx;
        pick  = rr_last;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(rr_last) + k) % N_MASTERS;
            if (!found && master_req[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

    assign pick_num = master_num[pick*SLAVE_WIDTH +: SLAVE_WIDTH];
    assign g_num    = master_num[grant*SLAVE_WIDTH +: SLAVE_WIDTH];
    assign g_req    = master_req[grant];

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_last_nxt  = rr_last;
        wdog_nxt     = '0;
        master_dat_i = '0;
        master_ready = '0;
        master_err   = '0;
        slave_dat_i  = '0;
        slave_addr   = '0;
        slave_mode   = '0;
        slave_wen    = '0;
        slave_req    = '0;
        s_rdy        = 1'b0;
        s_dat        = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt   = pick;
                    rr_last_nxt = pick;
                    state_nxt   = (int'(pick_num) < N_SLAVES) ? BUSY : ERR;
                end
            end
            BUSY: begin
                // The slave path is combinational from the master's live signals.
                for (int s = 0; s < N_SLAVES; s++) begin
                    if (g_num == SLAVE_WIDTH'(s)) begin
                        slave_req[s]              = g_req;
                        slave_wen[s]              = master_wen[grant];
                        slave_addr[s*AW +: AW]    = master_addr[grant*AW +: AW];
                        slave_mode[s*3 +: 3]      = master_mode[grant*3 +: 3];
                        slave_dat_i[s*XLEN +: XLEN] = master_dat_o[grant*XLEN +: XLEN];
                        s_rdy                     = slave_ready[s];
                        s_dat                     = slave_dat_o[s*XLEN +: XLEN];
                    end
                end
                if (!g_req) begin
                    state_nxt = IDLE;
                end else if (s_rdy) begin
                    master_ready[grant]              = 1'b1;
                    master_dat_i[grant*XLEN +: XLEN] = s_dat;
                    state_nxt                        = IDLE;
                end else if (wdog == WD_MAX) begin
                    state_nxt = ERR;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            ERR: begin
                master_ready[grant]              = 1'b1;
                master_err[grant]                = 1'b1;
                master_dat_i[grant*XLEN +: XLEN] = ERR_DATA;
                state_nxt                        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uib_arbiter.sv
// Randomized bench for uib_arbiter: a transaction-level model predicts every output each cycle,
// and directed scenarios pin the model with literal expectations.
module tb_uib_arbiter;
    localparam int XLEN = 32, SW = 4, NM = 4, NS = 3, TO = 8;
    localparam int AW = XLEN - SW;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;
    localparam int SW_BITS = NS*1 + NS*1 + NS*AW + NS*XLEN + NS*3;
    localparam int MW_BITS = NM + NM + NM*XLEN;

    logic clk = 0, rst = 1;
    logic [NM*XLEN-1:0] master_dat_o = '0, master_dat_i;
    logic [NM*AW-1:0]   master_addr = '0;
    logic [NM*SW-1:0]   master_num = '0;
    logic [NM*3-1:0]    master_mode = '0;
    logic [NM-1:0]      master_wen = '0, master_req = '0, master_ready, master_err;
    logic [NS*XLEN-1:0] slave_dat_i, slave_dat_o = '0;
    logic [NS*AW-1:0]   slave_addr;
    logic [NS*3-1:0]    slave_mode;
    logic [NS-1:0]      slave_wen, slave_req, slave_ready = '0;

    int vectors = 0, miscompares = 0;

    uib_arbiter #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .N_MASTERS(NM), .N_SLAVES(NS),
                  .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .master_dat_o(master_dat_o), .master_addr(master_addr), .master_num(master_num),
        .master_mode(master_mode), .master_wen(master_wen), .master_req(master_req),
        .master_dat_i(master_dat_i), .master_ready(master_ready), .master_err(master_err),
        .slave_dat_i(slave_dat_i), .slave_addr(slave_addr), .slave_mode(slave_mode),
        .slave_wen(slave_wen), .slave_req(slave_req), .slave_dat_o(slave_dat_o),
        .slave_ready(slave_ready));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 = no transfer, 1 = transfer owned by a slave, 2 = error reply owed
    int m_phase, m_owner, m_rr, m_wait, pick_m, own_num;

    function automatic int rr_pick(input int last, input logic [NM-1:0] req);
        for (int k = 1; k <= NM; k++)
            if (req[(last + k) % NM]) return (last + k) % NM;
        return -1;
    endfunction

    function automatic int num_of(input logic [NM*SW-1:0] nums, input int m);
        return int'(nums[m*SW +: SW]);
    endfunction

    always_comb begin
        pick_m  = rr_pick(m_rr, master_req);
        own_num = num_of(master_num, m_owner);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_owner <= 0; m_rr <= NM - 1; m_wait <= 0;
        end else if (m_phase == 0) begin
            if (pick_m >= 0) begin
                m_owner <= pick_m;
                m_rr    <= pick_m;
                m_phase <= (num_of(master_num, pick_m) < NS) ? 1 : 2;
                m_wait  <= 0;
            end
        end else if (m_phase == 1) begin
            if (!master_req[m_owner] || slave_ready[own_num]) m_phase <= 0;
            else if (m_wait == TO - 1) m_phase <= 2;
            else m_wait <= m_wait + 1;
        end else begin
            m_phase <= 0;
        end
    end

    logic [NM-1:0]      exp_mready, exp_merr;
    logic [NM*XLEN-1:0] exp_mdat;
    logic [NS-1:0]      exp_sreq, exp_swen;
    logic [NS*AW-1:0]   exp_saddr;
    logic [NS*XLEN-1:0] exp_sdat;
    logic [NS*3-1:0]    exp_smode;

    always @(negedge clk) begin
        logic [NM-1:0]      er, ee;
        logic [NM*XLEN-1:0] ed;
        logic [NS-1:0]      sq, sw;
        logic [NS*AW-1:0]   sa;
        logic [NS*XLEN-1:0] sd;
        logic [NS*3-1:0]    sm;
        er = '0; ee = '0; ed = '0; sq = '0; sw = '0; sa = '0; sd = '0; sm = '0;
        if (!rst && m_phase == 1) begin
            sq[own_num] = master_req[m_owner];
            sw[own_num] = master_wen[m_owner];
            sa[own_num*AW +: AW]     = master_addr[m_owner*AW +: AW];
            sd[own_num*XLEN +: XLEN] = master_dat_o[m_owner*XLEN +: XLEN];
            sm[own_num*3 +: 3]       = master_mode[m_owner*3 +: 3];
            if (master_req[m_owner] && slave_ready[own_num]) begin
                er[m_owner] = 1'b1;
                ed[m_owner*XLEN +: XLEN] = slave_dat_o[own_num*XLEN +: XLEN];
            end
        end else if (!rst && m_phase == 2) begin
            er[m_owner] = 1'b1;
            ee[m_owner] = 1'b1;
            ed[m_owner*XLEN +: XLEN] = ERRD;
        end
        exp_mready <= er; exp_merr <= ee; exp_mdat <= ed;
        exp_sreq <= sq; exp_swen <= sw; exp_saddr <= sa; exp_sdat <= sd; exp_smode <= sm;
        chk("slave_side", 256'({slave_req, slave_wen, slave_addr, slave_dat_i, slave_mode}),
            256'({sq, sw, sa, sd, sm}));
        chk("master_side", 256'({master_ready, master_err, master_dat_i}), 256'({er, ee, ed}));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1;
        master_req = '0; slave_ready = '0;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic set_req(input int m, input int num, input logic wen, input logic [31:0] dat,
                           input logic [AW-1:0] addr);
        master_num[m*SW +: SW]       = SW'(num);
        master_wen[m]                = wen;
        master_dat_o[m*XLEN +: XLEN] = dat;
        master_addr[m*AW +: AW]      = addr;
        master_mode[m*3 +: 3]        = 3'($urandom);
        master_req[m]                = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq [8];
        int cnt;
        bit got;
        seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};

        // reset state
        #2;
        chk("reset_outputs", 256'({master_ready, master_err, master_dat_i, slave_req, slave_wen,
                                   slave_addr, slave_dat_i, slave_mode}), 256'(0));
        do_reset();

        // single read, one wait state
        set_req(0, 0, 1'b0, 32'h0, AW'(28'h10));
        tick(); @(negedge clk);
        chk("t1_slave_req", 256'(slave_req), 256'(3'b001));
        chk("t1_addr", 256'(slave_addr[AW-1:0]), 256'(28'h10));
        chk("t1_no_ready_yet", 256'(master_ready), 256'(0));
        tick(); slave_ready[0] = 1'b1; slave_dat_o[31:0] = 32'h12345678;
        @(negedge clk);
        chk("t1_ready", 256'({master_ready, master_err}), 256'({4'b0001, 4'b0000}));
        chk("t1_data", 256'(master_dat_i[31:0]), 256'(32'h12345678));
        tick(); master_req = '0; slave_ready = '0;

        // two masters alternate with one IDLE cycle between grants
        do_reset();
        slave_ready[0] = 1'b1;
        set_req(0, 0, 1'b0, 32'h1, '0);
        set_req(1, 0, 1'b1, 32'h2, '0);
        for (int c = 0; c < 8; c++) begin
            tick(); @(negedge clk);
            chk($sformatf("t2_seq%0d", c), 256'(master_ready), 256'(seq[c]));
        end

        // decode miss
        do_reset();
        set_req(1, 7, 1'b1, 32'hA5A5A5A5, '0);
        tick(); @(negedge clk);
        chk("t3_resp", 256'({master_ready, master_err, slave_req}), 256'({4'b0010, 4'b0010, 3'b000}));
        chk("t3_data", 256'(master_dat_i[63:32]), 256'(ERRD));
        tick(); master_req = '0;

        // hung slave: slave_req held exactly TIMEOUT cycles, then error
        do_reset();
        set_req(0, 2, 1'b0, 32'h0, '0);
        cnt = 0; got = 0;
        for (int c = 0; c < 4*TO && !got; c++) begin
            tick(); @(negedge clk);
            if (slave_req[2]) cnt++;
            if (master_ready[0]) begin
                got = 1;
                chk("t4_err", 256'({master_err, slave_req}), 256'({4'b0001, 3'b000}));
            end
        end
        chk("t4_got_response", 256'(got), 256'(1));
        chk("t4_req_cycles", 256'(cnt), 256'(TO));
        tick(); master_req = '0;

        // ready in the last watchdog cycle wins over the timeout
        do_reset();
        set_req(0, 1, 1'b0, 32'h0, '0);
        repeat (TO) tick();
        slave_ready[1] = 1'b1; slave_dat_o[63:32] = 32'hCAFEF00D;
        @(negedge clk);
        chk("t5_ready_wins", 256'({master_ready, master_err}), 256'({4'b0001, 4'b0000}));
        chk("t5_data", 256'(master_dat_i[31:0]), 256'(32'hCAFEF00D));
        tick(); master_req = '0; slave_ready = '0;

        // reset mid-BUSY, then M0 wins first
        do_reset();
        set_req(2, 0, 1'b0, 32'h0, '0);
        repeat (3) tick();
        rst = 1; #1;
        chk("t5_rst_outputs", 256'({master_ready, master_err, master_dat_i, slave_req, slave_wen,
                                    slave_addr, slave_dat_i, slave_mode}), 256'(0));
        set_req(0, 0, 1'b0, 32'h0, '0);
        slave_ready[0] = 1'b1;
        tick(); rst = 0;
        tick(); @(negedge clk);
        chk("t5_first_grant_m0", 256'(master_ready), 256'(4'b0001));
        tick(); master_req = '0; slave_ready = '0;

        // round robin after an M3 grant picks M1
        do_reset();
        slave_ready[0] = 1'b1;
        set_req(3, 0, 1'b0, 32'h0, '0);
        tick(); @(negedge clk);
        chk("t6_m3_first", 256'(master_ready), 256'(4'b1000));
        tick(); set_req(1, 0, 1'b0, 32'h0, '0);
        tick(); @(negedge clk);
        chk("t6_m1_next", 256'(master_ready), 256'(4'b0010));
        tick(); master_req = '0; slave_ready = '0;

        // randomized traffic checked against the model every cycle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) rst = 0;
            else if ($urandom % 600 == 0) rst = 1;
            for (int m = 0; m < NM; m++) begin
                if (master_req[m]) begin
                    if (exp_mready[m] || $urandom % 300 == 0) master_req[m] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    set_req(m, int'($urandom % 5), 1'($urandom), $urandom, AW'($urandom));
                end
            end
            slave_ready[0] = ($urandom % 3 == 0);
            slave_ready[1] = ($urandom % 2 == 0);
            slave_ready[2] = ($urandom % 16 == 0);
            slave_dat_o = {$urandom, $urandom, $urandom};
        end
        tick(); @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
